// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Iterative RV64M divide/remainder unit (DIV/DIVU/REM/REMU and
//               W variants). Radix-2 restoring division, one quotient bit per
//               cycle, with a busy/done handshake and a kill input for flushes.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic            op_w,
    input  logic            kill,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int            c_CNT_W = $clog2(XLEN) + 1;
    localparam logic [1:0]    c_IDLE  = 2'd0;
    localparam logic [1:0]    c_CALC  = 2'd1;
    localparam logic [1:0]    c_DONE  = 2'd2;
    localparam logic [XLEN-1:0] c_ONE = {{(XLEN-1){1'b0}}, 1'b1};

    logic [1:0]         r_state;
    logic               r_is_rem;
    logic               r_w;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [XLEN-1:0]    r_rem;
    logic [XLEN-1:0]    r_quo;
    logic [XLEN-1:0]    r_div;
    logic [c_CNT_W-1:0] r_cnt;

    // Operand preparation: extension for W ops, sign flags and magnitudes
    logic            w_signed;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic [XLEN-1:0] w_min;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN-1:0] w_spec_raw;
    logic [XLEN-1:0] w_spec_res;

    assign w_signed = ~op[0];
    assign w_a = op_w ? {{(XLEN-32){w_signed & rs1_data[31]}}, rs1_data[31:0]} : rs1_data;
    assign w_b = op_w ? {{(XLEN-32){w_signed & rs2_data[31]}}, rs2_data[31:0]} : rs2_data;
    assign w_a_neg = w_signed & w_a[XLEN-1];
    assign w_b_neg = w_signed & w_b[XLEN-1];
    assign w_a_mag = w_a_neg ? (~w_a + c_ONE) : w_a;
    assign w_b_mag = w_b_neg ? (~w_b + c_ONE) : w_b;

    // Most-negative value at operand width (sign-extended for W ops)
    assign w_min = op_w ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    assign w_div0 = (w_b == '0);
    assign w_ovf  = w_signed & (w_a == w_min) & (w_b == '1);

    // Divide-by-zero: q = all ones, r = dividend. Overflow: q = dividend, r = 0
    assign w_spec_raw = w_div0 ? (op[1] ? w_a : '1) : (op[1] ? '0 : w_a);
    assign w_spec_res = op_w ? {{(XLEN-32){w_spec_raw[31]}}, w_spec_raw[31:0]} : w_spec_raw;

    // One restoring-division step; remainder stays below the divisor so the
    // shifted value always fits in XLEN bits
    logic [XLEN-1:0] w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_qbit;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;
    logic [XLEN-1:0] w_q_fin;
    logic [XLEN-1:0] w_r_fin;
    logic [XLEN-1:0] w_sel;
    logic [XLEN-1:0] w_calc_res;

    assign w_shift   = {r_rem[XLEN-2:0], r_quo[XLEN-1]};
    assign w_diff    = {1'b0, w_shift} - {1'b0, r_div};
    assign w_qbit    = ~w_diff[XLEN];
    assign w_rem_nxt = w_qbit ? w_diff[XLEN-1:0] : w_shift;
    assign w_quo_nxt = {r_quo[XLEN-2:0], w_qbit};

    // Sign correction on the final step; W results are sign-extended from bit 31
    assign w_q_fin    = r_neg_q ? (~w_quo_nxt + c_ONE) : w_quo_nxt;
    assign w_r_fin    = r_neg_r ? (~w_rem_nxt + c_ONE) : w_rem_nxt;
    assign w_sel      = r_is_rem ? w_r_fin : w_q_fin;
    assign w_calc_res = r_w ? {{(XLEN-32){w_sel[31]}}, w_sel[31:0]} : w_sel;

    // Control FSM and datapath registers; all outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= c_IDLE;
            r_is_rem <= 1'b0;
            r_w      <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start && !kill) begin
                        r_is_rem <= op[1];
                        r_w      <= op_w;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_div    <= w_b_mag;
                        r_rem    <= '0;
                        // W dividends sit in the top 32 bits so their MSB shifts out first
                        r_quo    <= op_w ? {w_a_mag[31:0], {(XLEN-32){1'b0}}} : w_a_mag;
                        r_cnt    <= op_w ? c_CNT_W'(32) : c_CNT_W'(XLEN);
                        busy     <= 1'b1;
                        if (w_div0 || w_ovf) begin
                            r_state <= c_DONE;
                            done    <= 1'b1;
                            result  <= w_spec_res;
                        end else begin
                            r_state <= c_CALC;
                        end
                    end
                end
                c_CALC: begin
                    if (kill) begin
                        r_state <= c_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt - c_CNT_W'(1);
                        if (r_cnt == c_CNT_W'(1)) begin
                            r_state <= c_DONE;
                            done    <= 1'b1;
                            result  <= w_calc_res;
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    r_state <= c_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Self-checking bench for div_unit. An arithmetic reference
//               model tracks busy/done/result every cycle; directed vectors
//               pin results and latencies to hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic [1:0]  op     = 2'b00;
    logic        op_w   = 1'b0;
    logic        kill   = 1'b0;
    logic [63:0] rs1    = '0;
    logic [63:0] rs2    = '0;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    div_unit #(.XLEN(64)) dut (
        .clk      (clk),
        .rst      (rst_n),
        .start    (start),
        .op       (op),
        .op_w     (op_w),
        .kill     (kill),
        .rs1_data (rs1),
        .rs2_data (rs2),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Special cases judged at operand width
    function automatic logic is_special(input logic [1:0] f_op, input logic f_w,
                                        input logic [63:0] a, input logic [63:0] b);
        if (f_w)
            return (b[31:0] == 32'd0) ||
                   (!f_op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        else
            return (b == 64'd0) ||
                   (!f_op[0] && a == 64'h8000_0000_0000_0000 && b == '1);
    endfunction

    // Reference result straight from the RISC-V M-extension rules
    function automatic logic [63:0] model_res(input logic [1:0] f_op, input logic f_w,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a32, b32, r32;
        logic [63:0] r64;
        if (f_w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 0)
                r32 = f_op[1] ? a32 : 32'hFFFF_FFFF;
            else if (!f_op[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF)
                r32 = f_op[1] ? 32'd0 : a32;
            else begin
                case (f_op)
                    2'b00:   r32 = $signed(a32) / $signed(b32);
                    2'b01:   r32 = a32 / b32;
                    2'b10:   r32 = $signed(a32) % $signed(b32);
                    default: r32 = a32 % b32;
                endcase
            end
            return {{32{r32[31]}}, r32};
        end else begin
            if (b == 0)
                r64 = f_op[1] ? a : '1;
            else if (!f_op[0] && a == 64'h8000_0000_0000_0000 && b == '1)
                r64 = f_op[1] ? 64'd0 : a;
            else begin
                case (f_op)
                    2'b00:   r64 = $signed(a) / $signed(b);
                    2'b01:   r64 = a / b;
                    2'b10:   r64 = $signed(a) % $signed(b);
                    default: r64 = a % b;
                endcase
            end
            return r64;
        end
    endfunction

    // Cycle-level expectation: busy/done/result derived from latency rules
    logic        m_busy    = 1'b0;
    logic        m_done    = 1'b0;
    logic [63:0] m_result  = '0;
    logic [63:0] m_pending = '0;
    int          m_left    = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_result <= '0;
            m_left   <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (kill)
                m_busy <= 1'b0;
            else if (m_left == 1) begin
                m_done   <= 1'b1;
                m_result <= m_pending;
            end else
                m_left <= m_left - 1;
        end else if (start && !kill) begin
            m_busy    <= 1'b1;
            m_pending <= model_res(op, op_w, rs1, rs2);
            if (is_special(op, op_w, rs1, rs2)) begin
                m_done   <= 1'b1;
                m_result <= model_res(op, op_w, rs1, rs2);
            end else
                m_left <= op_w ? 32 : 64;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        check("busy", {63'd0, busy}, {63'd0, m_busy});
        check("done", {63'd0, done}, {63'd0, m_done});
        check("result", result, m_result);
    end

    // Issue one op; latency counts the accept edge as edge 1
    task automatic run_op(input string name, input logic [1:0] f_op, input logic f_w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] lit, input int lat);
        int edges;
        @(negedge clk);
        op = f_op; op_w = f_w; rs1 = a; rs2 = b; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        edges = 1;
        while (!done && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        check({name, " result"}, result, lit);
        check({name, " latency"}, 64'(edges), 64'(lat));
        check({name, " model"}, model_res(f_op, f_w, a, b), lit);
        @(posedge clk); #1;
    endtask

    initial begin
        int edges;
        int done_seen;
        #500000;
        $display("FAIL timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        int edges;
        int done_seen;
        #12;
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset result", result, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op("divu", 2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 65);
        run_op("remu", 2'b11, 1'b0, 64'd100, 64'd7, 64'd2, 65);
        run_op("div neg", 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run_op("rem neg", 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run_op("div by0", 2'b00, 1'b0, 64'd42, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("remu by0", 2'b11, 1'b0, 64'd42, 64'd0, 64'd42, 1);
        run_op("div ovf", 2'b00, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
        run_op("rem ovf", 2'b10, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
        run_op("divw ovf", 2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
        run_op("divuw", 2'b01, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        run_op("remw", 2'b10, 1'b1, 64'hFFFF_FFFF_FFFF_FFF7, 64'd4, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        run_op("divuw half", 2'b01, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 33);
        run_op("divu big", 2'b01, 1'b0, '1, 64'h8000_0000_0000_0000, 64'd1, 65);
        run_op("remu big", 2'b11, 1'b0, '1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 65);
        run_op("div min2", 2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'hC000_0000_0000_0000, 65);
        run_op("remuw by0", 2'b11, 1'b1, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0001, 1);

        // kill at iteration 10: no done, result keeps prior value
        @(negedge clk);
        op = 2'b01; op_w = 1'b0; rs1 = 64'd1000; rs2 = 64'd3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        kill = 1'b1;
        @(posedge clk); #1 kill = 1'b0;
        check("kill busy", {63'd0, busy}, 64'd0);
        check("kill done", {63'd0, done}, 64'd0);
        check("kill result", result, 64'hFFFF_FFFF_8000_0001);
        done_seen = 0;
        repeat (70) begin @(posedge clk); #1; if (done) done_seen++; end
        check("kill no done", 64'(done_seen), 64'd0);

        // start while busy is ignored, including on the DONE cycle
        @(negedge clk);
        op = 2'b01; op_w = 1'b0; rs1 = 64'd100; rs2 = 64'd7; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        op = 2'b11; rs1 = 64'd1000; rs2 = 64'd1; start = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        start = 1'b0;
        edges = 0;
        while (!done && edges < 100) begin @(posedge clk); #1; edges++; end
        check("busy-start result", result, 64'd14);
        op = 2'b01; rs1 = 64'd50; rs2 = 64'd5; start = 1'b1;
        @(posedge clk); #1;
        check("done-cycle start busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1 start = 1'b0;
        check("next-idle accept busy", {63'd0, busy}, 64'd1);
        edges = 1;
        while (!done && edges < 100) begin @(posedge clk); #1; edges++; end
        check("late accept result", result, 64'd10);
        check("late accept latency", 64'(edges), 64'd65);
        @(posedge clk); #1;

        // asynchronous reset mid-CALC clears everything at once
        @(negedge clk);
        op = 2'b01; rs1 = 64'd999; rs2 = 64'd4; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        #1 rst_n = 1'b0;
        #1;
        check("rst busy", {63'd0, busy}, 64'd0);
        check("rst done", {63'd0, done}, 64'd0);
        check("rst result", result, 64'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run_op("post-rst divu", 2'b01, 1'b0, 64'd999, 64'd4, 64'd249, 65);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
